rf_scrubber: RTL and testbench
==============================

RF_SCRUBBER -- requirements
Module: cv32e40s_rf_scrubber

Interface
REQ-001 Parameter SCRUB_INTERVAL, default 64: idle cycles between scrub reads; legal range 1..65535.
REQ-002 Parameter MAJOR_THRESHOLD, default 4: error count at which the major alert asserts; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port enable_i  input  1  scrubbing enabled.
REQ-006 Port port_free_i  input  1  the register-file spare read port is unused by the pipeline this cycle.
REQ-007 Port scrub_req_o  output  1  scrub read requested on the spare read port.
REQ-008 Port scrub_raddr_o  output  5  register address driven to the spare read port.
REQ-009 Port ecc_err_i  input  1  ECC error flag from the register-file wrapper; combinational result of the current spare-port read.
REQ-010 Port alert_minor_o  output  1  one-cycle pulse per detected error.
REQ-011 Port alert_major_o  output  1  sticky; error count reached MAJOR_THRESHOLD.
REQ-012 Port err_cnt_o  output  8  saturating count of detected errors.
REQ-013 Port err_addr_o  output  5  address of the most recent failing read.
REQ-014 Port sweep_done_o  output  1  one-cycle pulse when address 31 is read successfully.

Function
REQ-015 FSM states: IDLE, WAIT, READ.
REQ-016 IDLE: scrub_req_o=0; enable_i=1 -> WAIT with the interval counter loaded to SCRUB_INTERVAL-1.
REQ-017 WAIT: counter decrements by 1 each cycle; counter==0 -> READ.
REQ-018 READ: scrub_req_o=1 and scrub_raddr_o=current address; stays in READ until port_free_i=1.
REQ-019 A read completes in the cycle in which scrub_req_o=1 and port_free_i=1; ecc_err_i is sampled only in that cycle and ignored in all other cycles.
REQ-020 After a completed read: address advances 1->2->...->31->1, wraps to 1, never visits 0; FSM -> WAIT with the counter reloaded.
REQ-021 sweep_done_o pulses in the cycle after a completed read of address 31.
REQ-022 Completed read with ecc_err_i=1, registered on the next edge:
  - alert_minor_o=1 for exactly one cycle;
  - err_addr_o=read address;
  - err_cnt_o increments, saturating at 255.
REQ-023 alert_major_o sets in the same cycle err_cnt_o first becomes >= MAJOR_THRESHOLD and remains 1 until reset.
REQ-024 enable_i=0 in any state -> IDLE on the next edge:
  - a READ in progress is abandoned;
  - the current address is retained;
  - error state is retained.
REQ-025 enable_i falling in the same cycle as a completed read: the read result is still recorded; FSM -> IDLE.
REQ-026 Consecutive errors on back-to-back completed reads each produce a separate alert_minor_o pulse; no pulse merging.

Reset
REQ-027 rst=1 at any clock edge, including mid-READ:
  - FSM -> IDLE; address -> 1; interval counter -> 0;
  - err_cnt_o=0, err_addr_o=0;
  - alert_minor_o=0, alert_major_o=0, sweep_done_o=0, scrub_req_o=0;
  - scrub_raddr_o=1.
REQ-028 rst has priority over enable_i and every other input.

Configuration
REQ-029 Macro CV32E40S_RF_SCRUB_ERRCNT_EN defined: err_cnt_o and alert_major_o behave as in REQ-022 and REQ-023.
REQ-030 Macro CV32E40S_RF_SCRUB_ERRCNT_EN undefined:
  - the error counter is removed;
  - err_cnt_o is tied to 0;
  - alert_major_o is tied to 0;
  - all other behaviour is unchanged.

Verification
REQ-031 SCRUB_INTERVAL=4, enable_i=1, port_free_i=1, no errors -> scrub_req_o high every 5th cycle; addresses 1..31 then 1; sweep_done_o pulses once per sweep.
REQ-032 port_free_i=0 for 10 cycles during READ -> scrub_req_o held with a stable address; the read completes on the first cycle port_free_i=1.
REQ-033 ecc_err_i=1 on the read of address 7 -> alert_minor_o single-cycle pulse; err_addr_o=7; err_cnt_o=1.
REQ-034 MAJOR_THRESHOLD=2, errors on two reads -> alert_major_o sets with err_cnt_o=2 and stays high after later clean reads; 300 errors -> err_cnt_o=255.
REQ-035 enable_i dropped mid-READ at address 12, re-enabled later -> next completed read is address 12; rst mid-READ -> all outputs at reset values and the next read is address 1.
REQ-036 Build without CV32E40S_RF_SCRUB_ERRCNT_EN, inject errors -> alert_minor_o pulses; err_cnt_o=0; alert_major_o=0.

Source files
------------

// File: rtl/rf_scrubber_if.sv
// Scrubber <-> register-file spare-port and alert bundle.
// master = scrubber side, slave = register-file wrapper / alert consumer side.
interface rf_scrubber_if;
  logic       enable_i;
  logic       port_free_i;
  logic       scrub_req_o;
  logic [4:0] scrub_raddr_o;
  logic       ecc_err_i;
  logic       alert_minor_o;
  logic       alert_major_o;
  logic [7:0] err_cnt_o;
  logic [4:0] err_addr_o;
  logic       sweep_done_o;

  modport master (
    input  enable_i, port_free_i, ecc_err_i,
    output scrub_req_o, scrub_raddr_o, alert_minor_o, alert_major_o,
           err_cnt_o, err_addr_o, sweep_done_o
  );

  modport slave (
    output enable_i, port_free_i, ecc_err_i,
    input  scrub_req_o, scrub_raddr_o, alert_minor_o, alert_major_o,
           err_cnt_o, err_addr_o, sweep_done_o
  );
endinterface

// File: rtl/rf_scrubber.sv
// Background register-file ECC scrubber: reads x1..x31 on the spare port every SCRUB_INTERVAL idle cycles.
// Latency: alerts/status register one edge after the completing read; stalls in READ until port_free_i.
// Optional error counter and major alert enabled by CV32E40S_RF_SCRUB_ERRCNT_EN (tied to 0 otherwise).
module rf_scrubber #(
  parameter int unsigned SCRUB_INTERVAL  = 64,
  parameter int unsigned MAJOR_THRESHOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_scrubber_if.master  sif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ
  } state_e;

  localparam logic [15:0] IVL_RELOAD = 16'(SCRUB_INTERVAL - 1);

  state_e      state_q, state_d;
  logic [15:0] ivl_q, ivl_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  err_addr_q, err_addr_d;
  logic        minor_q, minor_d;
  logic        sweep_q, sweep_d;

  logic rd_done;
  logic rd_err;

  // A read only counts when the pipeline leaves the spare port free; ecc_err_i is meaningless otherwise.
  assign rd_done = (state_q == ST_READ) && sif.port_free_i;
  assign rd_err  = rd_done && sif.ecc_err_i;

  always_comb begin
    state_d    = state_q;
    ivl_d      = ivl_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    minor_d    = rd_err;
    sweep_d    = rd_done && !sif.ecc_err_i && (addr_q == 5'd31);

    if (rd_err) begin
      err_addr_d = addr_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sif.enable_i) begin
          state_d = ST_WAIT;
          ivl_d   = IVL_RELOAD;
        end
      end
      ST_WAIT: begin
        if (!sif.enable_i) begin
          state_d = ST_IDLE;
        end else if (ivl_q == 16'd0) begin
          state_d = ST_READ;
        end else begin
          ivl_d = ivl_q - 16'd1;
        end
      end
      ST_READ: begin
        // A completing read is recorded even if enable drops in the same cycle.
        if (rd_done) begin
          addr_d  = (addr_q == 5'd31) ? 5'd1 : addr_q + 5'd1;
          ivl_d   = IVL_RELOAD;
          state_d = sif.enable_i ? ST_WAIT : ST_IDLE;
        end else if (!sif.enable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ivl_q      <= 16'd0;
      addr_q     <= 5'd1;
      err_addr_q <= 5'd0;
      minor_q    <= 1'b0;
      sweep_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      minor_q    <= minor_d;
      sweep_q    <= sweep_d;
    end
  end

  assign sif.scrub_req_o   = (state_q == ST_READ);
  assign sif.scrub_raddr_o = addr_q;
  assign sif.alert_minor_o = minor_q;
  assign sif.err_addr_o    = err_addr_q;
  assign sif.sweep_done_o  = sweep_q;

`ifdef CV32E40S_RF_SCRUB_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       major_q, major_d;

  // Major alert tracks the post-increment count so it rises together with err_cnt_o.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_err && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
    major_d = major_q || (cnt_d >= 8'(MAJOR_THRESHOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      major_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      major_q <= major_d;
    end
  end

  assign sif.err_cnt_o     = cnt_q;
  assign sif.alert_major_o = major_q;
`else
  logic [7:0] unused_major_threshold;
  assign unused_major_threshold = 8'(MAJOR_THRESHOLD);
  assign sif.err_cnt_o     = 8'd0;
  assign sif.alert_major_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_scrubber.sv
// Directed bench for rf_scrubber: expected reads queued by the stimulus, checked when the DUT completes them.
module tb_rf_scrubber;

  localparam int unsigned IVL = 4;
  localparam int unsigned THR = 2;
`ifdef CV32E40S_RF_SCRUB_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0] addr;
    bit         err;
  } rd_t;

  logic clk;
  logic rst;
  rf_scrubber_if sif ();

  rf_scrubber #(.SCRUB_INTERVAL(IVL), .MAJOR_THRESHOLD(THR)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = -1;
  bit gap_chk = 1'b0;
  bit noise = 1'b0;
  int sweep_seen = 0;

  rd_t q[$];
  logic [4:0] next_addr = 5'd1;
  int m_cnt = 0;
  bit m_major = 1'b0;
  logic [4:0] m_err_addr = 5'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input bit err);
    for (int i = 0; i < n; i++) begin
      q.push_back('{addr: next_addr, err: err});
      next_addr = (next_addr == 5'd31) ? 5'd1 : next_addr + 5'd1;
    end
  endtask

  // One clock: detect completion before the edge, check registered outputs after it.
  task automatic tick();
    rd_t e;
    bit  comp;
    e = '{addr: 5'd0, err: 1'b0};
    #4;
    comp = sif.scrub_req_o && sif.port_free_i && !rst;
    if (comp) begin
      chk("read_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) e = q.pop_front();
      chk("raddr", 32'(sif.scrub_raddr_o), 32'(e.addr));
      sif.ecc_err_i = e.err;
      if (gap_chk && last_cyc >= 0) chk("req_period", 32'(cyc - last_cyc), 32'd5);
      last_cyc = cyc;
    end else begin
      sif.ecc_err_i = noise;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_cnt = 0;
      m_major = 1'b0;
      m_err_addr = 5'd0;
    end else if (comp && e.err) begin
      m_err_addr = e.addr;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt >= THR) m_major = 1'b1;
    end
    if (sif.sweep_done_o === 1'b1) sweep_seen++;
    chk("alert_minor", 32'(sif.alert_minor_o), 32'(comp && e.err));
    chk("sweep_done", 32'(sif.sweep_done_o), 32'(comp && !e.err && e.addr == 5'd31));
    chk("err_addr", 32'(sif.err_addr_o), 32'(m_err_addr));
    chk("err_cnt", 32'(sif.err_cnt_o), CNT_EN ? 32'(m_cnt) : 32'd0);
    chk("alert_major", 32'(sif.alert_major_o), 32'(CNT_EN && m_major));
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (sif.scrub_req_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("req_timeout", 32'(sif.scrub_req_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    sif.enable_i = 1'b0;
    sif.port_free_i = 1'b0;
    sif.ecc_err_i = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(sif.scrub_req_o), 32'd0);
    chk("rst_raddr", 32'(sif.scrub_raddr_o), 32'd1);
    rst = 1'b0;

    // Full sweep with free port: 1..31, wrap to 1, every 5th cycle.
    sif.enable_i = 1'b1;
    sif.port_free_i = 1'b1;
    gap_chk = 1'b1;
    sweep_seen = 0;
    push(33, 1'b0);
    drain(400);
    gap_chk = 1'b0;
    chk("sweep_count", 32'(sweep_seen), 32'd1);

    // Port busy for 10 cycles in READ with ecc_err noise: request and address hold.
    sif.port_free_i = 1'b0;
    wait_req(20);
    noise = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_req", 32'(sif.scrub_req_o), 32'd1);
      chk("stall_raddr", 32'(sif.scrub_raddr_o), 32'd3);
    end
    noise = 1'b0;
    sif.port_free_i = 1'b1;
    push(1, 1'b0);
    drain(5);

    // Errors on 7 and 8, then clean reads: major stays set.
    push(3, 1'b0);
    push(2, 1'b1);
    push(2, 1'b0);
    drain(100);
    chk("err_addr_8", 32'(sif.err_addr_o), 32'd8);

    // Disable mid-READ at address 12, re-enable: 12 is read next.
    push(1, 1'b0);
    drain(20);
    sif.port_free_i = 1'b0;
    wait_req(20);
    chk("abandon_raddr", 32'(sif.scrub_raddr_o), 32'd12);
    sif.enable_i = 1'b0;
    tick();
    chk("abandon_req", 32'(sif.scrub_req_o), 32'd0);
    repeat (7) tick();
    chk("idle_req", 32'(sif.scrub_req_o), 32'd0);
    sif.enable_i = 1'b1;
    sif.port_free_i = 1'b1;
    push(1, 1'b0);
    drain(20);

    // Enable falls in the completing cycle: error on 13 still recorded.
    push(1, 1'b1);
    sif.port_free_i = 1'b0;
    wait_req(20);
    sif.enable_i = 1'b0;
    sif.port_free_i = 1'b1;
    tick();
    chk("late_disable_q", 32'(q.size()), 32'd0);
    tick();
    chk("late_disable_req", 32'(sif.scrub_req_o), 32'd0);
    sif.enable_i = 1'b1;
    push(1, 1'b0);
    drain(20);

    // 300 errors: counter saturates.
    push(300, 1'b1);
    drain(2000);
    chk("cnt_sat", 32'(sif.err_cnt_o), CNT_EN ? 32'd255 : 32'd0);

    // Reset mid-READ: reset values, next read is address 1.
    sif.port_free_i = 1'b0;
    wait_req(20);
    rst = 1'b1;
    tick();
    chk("rst2_req", 32'(sif.scrub_req_o), 32'd0);
    chk("rst2_raddr", 32'(sif.scrub_raddr_o), 32'd1);
    rst = 1'b0;
    next_addr = 5'd1;
    sif.port_free_i = 1'b1;
    push(1, 1'b0);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
